lfsr_tx_feeder: RTL and testbench

LFSR_TX_FEEDER -- requirements
Module: lfsr_tx_feeder

---
 rtl/lfsr_tx_feeder_pkg.sv | 17 +
 rtl/lfsr_tx_feeder.sv | 121 ++++++++++++
 tb/tb_lfsr_tx_feeder.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_tx_feeder_pkg.sv
// Shared constants and state encoding for the LFSR-to-UART burst feeder.
package lfsr_tx_feeder_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 16;
  localparam int GAP_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
  } state_e;

endpackage

// File: rtl/lfsr_tx_feeder.sv
// Pulls bytes from an upstream LFSR and hands them one at a time to a UART
// transmitter, in bursts of BURST_LEN with optional idle gaps between bytes.
module lfsr_tx_feeder
  import lfsr_tx_feeder_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic              i_Clock,
  input  logic              i_Rst_L,
  input  logic              i_Start,
  input  logic              i_Abort,
  input  logic [BYTE_W-1:0] i_LFSR_Byte,
  output logic              o_LFSR_Enable,
  output logic              o_TX_DV,
  output logic [BYTE_W-1:0] o_TX_Byte,
  input  logic              i_TX_Active,
  input  logic              i_TX_Done,
  output logic              o_Busy,
  output logic              o_Done,
  output logic [CNT_W-1:0]  o_Byte_Count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_e              state_q;
  logic [GAP_W-1:0]    gap_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic                abort_q;
  logic [BYTE_W-1:0]   tx_byte_q;
  logic                en_q;
  logic                dv_q;
  logic                done_q;

  assign cnt_d = cnt_q + CNT_W'(1);

  // The advance strobe is launched by the capture edge, so an abort seen in
  // LOAD suppresses both the capture and the LFSR step.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      tx_byte_q <= '0;
      en_q      <= 1'b0;
      dv_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      dv_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_Start) begin
            cnt_q   <= '0;
            abort_q <= 1'b0;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (i_Abort) begin
            state_q <= S_IDLE;
          end else begin
            tx_byte_q <= i_LFSR_Byte;
            en_q      <= 1'b1;
            state_q   <= S_SEND;
          end
        end
        S_SEND: begin
          if (i_Abort) begin
            state_q <= S_IDLE;
          end else if (!i_TX_Active) begin
            dv_q    <= 1'b1;
            state_q <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          // A byte already handed to the UART is always allowed to finish.
          if (i_TX_Done) begin
            cnt_q <= cnt_d;
            if (abort_q || i_Abort) begin
              state_q <= S_IDLE;
            end else if (cnt_d == LAST_CNT) begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end else if (GAP_CYCLES > 0) begin
              gap_q   <= '0;
              state_q <= S_GAP;
            end else begin
              state_q <= S_LOAD;
            end
          end else if (i_Abort) begin
            abort_q <= 1'b1;
          end
        end
        S_GAP: begin
          if (i_Abort) begin
            state_q <= S_IDLE;
          end else if (gap_q == GAP_LAST) begin
            state_q <= S_LOAD;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        S_FINISH: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

  assign o_LFSR_Enable = en_q;
  assign o_TX_DV       = dv_q;
  assign o_TX_Byte     = tx_byte_q;
  assign o_Busy        = (state_q != S_IDLE);
  assign o_Done        = done_q;
  assign o_Byte_Count  = cnt_q;

endmodule

// File: tb/tb_lfsr_tx_feeder.sv
// Directed bench: two feeder instances (3-byte/no gap, 5-byte/4-clock gap)
// driven by a 16-bit XNOR LFSR model (seed ACE1) and a small UART TX model.
module tb_lfsr_tx_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        start [2];
  logic        abort [2];
  logic        ext_active [2];
  logic        ext_done [2];
  logic [15:0] lfsr [2];
  logic        m_active [2];
  logic        m_done [2];
  int          m_cnt [2];

  logic        en [2];
  logic        dv [2];
  logic        busy [2];
  logic        done_o [2];
  logic [7:0]  txb [2];
  logic [15:0] bcnt [2];

  int          en_cnt [2];
  int          dv_cnt [2];
  int          done_cnt [2];
  int          txd_cnt [2];
  logic [7:0]  bytes [2][16];
  int          en_cyc [2][16];
  int          dv_cyc [2][16];
  int          txd_cyc [2][16];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  lfsr_tx_feeder #(.BURST_LEN(3), .GAP_CYCLES(0)) u_dut0 (
    .i_Clock(clk), .i_Rst_L(rst_n[0]), .i_Start(start[0]), .i_Abort(abort[0]),
    .i_LFSR_Byte(lfsr[0][7:0]), .o_LFSR_Enable(en[0]), .o_TX_DV(dv[0]),
    .o_TX_Byte(txb[0]), .i_TX_Active(m_active[0] | ext_active[0]),
    .i_TX_Done(m_done[0] | ext_done[0]), .o_Busy(busy[0]), .o_Done(done_o[0]),
    .o_Byte_Count(bcnt[0])
  );

  lfsr_tx_feeder #(.BURST_LEN(5), .GAP_CYCLES(4)) u_dut1 (
    .i_Clock(clk), .i_Rst_L(rst_n[1]), .i_Start(start[1]), .i_Abort(abort[1]),
    .i_LFSR_Byte(lfsr[1][7:0]), .o_LFSR_Enable(en[1]), .o_TX_DV(dv[1]),
    .o_TX_Byte(txb[1]), .i_TX_Active(m_active[1] | ext_active[1]),
    .i_TX_Done(m_done[1] | ext_done[1]), .o_Busy(busy[1]), .o_Done(done_o[1]),
    .o_Byte_Count(bcnt[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // LFSR, UART model and event recorder; all work on the falling edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) begin
        lfsr[d] = 16'hACE1; m_active[d] = 1'b0; m_done[d] = 1'b0; m_cnt[d] = 0;
        en_cnt[d] = 0; dv_cnt[d] = 0; done_cnt[d] = 0; txd_cnt[d] = 0;
      end else begin
        if (en[d]) begin
          if (en_cnt[d] < 16) en_cyc[d][en_cnt[d]] = cyc;
          en_cnt[d]++;
          lfsr[d] = {lfsr[d][14:0], ~(lfsr[d][15] ^ lfsr[d][14] ^ lfsr[d][12] ^ lfsr[d][3])};
        end
        m_done[d] = 1'b0;
        if (m_active[d]) begin
          m_cnt[d]--;
          if (m_cnt[d] == 0) begin
            m_active[d] = 1'b0;
            m_done[d] = 1'b1;
            if (txd_cnt[d] < 16) txd_cyc[d][txd_cnt[d]] = cyc + 1;
            txd_cnt[d]++;
          end
        end
        if (dv[d]) begin
          if (dv_cnt[d] < 16) begin
            bytes[d][dv_cnt[d]] = txb[d];
            dv_cyc[d][dv_cnt[d]] = cyc;
          end
          dv_cnt[d]++;
          m_active[d] = 1'b1;
          m_cnt[d] = 3;
        end
        if (done_o[d]) done_cnt[d]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic reset_dut(input int d);
    rst_n[d] = 1'b0;
    tick(2);
    rst_n[d] = 1'b1;
    tick(1);
  endtask

  task automatic pulse_start(input int d);
    start[d] = 1'b1;
    tick(1);
    start[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, output bit to);
    for (int i = 0; i < 400 && busy[d]; i++) tick(1);
    to = busy[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; start[d] = 1'b0; abort[d] = 1'b0;
      ext_active[d] = 1'b0; ext_done[d] = 1'b0;
    end
    tick(2);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({en[d], dv[d], busy[d], done_o[d], txb[d], bcnt[d]} !== 28'h0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d got %h exp 0", d,
                 {en[d], dv[d], busy[d], done_o[d], txb[d], bcnt[d]});
      end
      rst_n[d] = 1'b1;
    end
    tick(1);
  endtask

  task automatic test_burst();
    int c0;
    bit to;
    reset_dut(0);
    c0 = cyc + 1;
    pulse_start(0);
    n_tests++;
    if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL burst_busy got %b exp 1", busy[0]); end
    wait_idle(0, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL burst_timeout busy still %b exp 0", busy[0]); end
    n_tests++;
    if (dv_cyc[0][0] !== c0 + 2) begin
      n_fail++; $display("FAIL burst_first_dv got cycle %0d exp %0d", dv_cyc[0][0], c0 + 2);
    end
    n_tests++;
    if ({bytes[0][0], bytes[0][1], bytes[0][2]} !== 24'hE1C285) begin
      n_fail++; $display("FAIL burst_bytes got %h exp e1c285", {bytes[0][0], bytes[0][1], bytes[0][2]});
    end
    n_tests++;
    if (dv_cnt[0] != 3 || en_cnt[0] != 3) begin
      n_fail++; $display("FAIL burst_strobes got dv %0d en %0d exp 3 3", dv_cnt[0], en_cnt[0]);
    end
    n_tests++;
    if (done_cnt[0] != 1) begin n_fail++; $display("FAIL burst_done got %0d exp 1", done_cnt[0]); end
    n_tests++;
    if (bcnt[0] !== 16'd3) begin n_fail++; $display("FAIL burst_count got %0d exp 3", bcnt[0]); end
    // No gap: TX_Done edge, then LOAD, then the enable cycle.
    n_tests++;
    if (en_cyc[0][1] - txd_cyc[0][0] != 1) begin
      n_fail++; $display("FAIL burst_nogap got %0d exp 1", en_cyc[0][1] - txd_cyc[0][0]);
    end
  endtask

  task automatic test_tx_busy();
    int c_rel;
    bit to;
    reset_dut(0);
    ext_active[0] = 1'b1;
    pulse_start(0);
    tick(9);
    n_tests++;
    if (dv_cnt[0] != 0 || en_cnt[0] != 1) begin
      n_fail++; $display("FAIL txbusy_hold got dv %0d en %0d exp 0 1", dv_cnt[0], en_cnt[0]);
    end
    c_rel = cyc + 1;
    ext_active[0] = 1'b0;
    for (int i = 0; i < 50 && dv_cnt[0] == 0; i++) tick(1);
    n_tests++;
    if (dv_cnt[0] != 1 || dv_cyc[0][0] != c_rel || en_cnt[0] != 1) begin
      n_fail++; $display("FAIL txbusy_release got dv %0d at %0d en %0d exp 1 at %0d en 1",
                         dv_cnt[0], dv_cyc[0][0], en_cnt[0], c_rel);
    end
    wait_idle(0, to);
    n_tests++;
    if (to || done_cnt[0] != 1 || {bytes[0][0], bytes[0][1], bytes[0][2]} !== 24'hE1C285) begin
      n_fail++; $display("FAIL txbusy_burst got to %0b done %0d bytes %h exp 0 1 e1c285",
                         to, done_cnt[0], {bytes[0][0], bytes[0][1], bytes[0][2]});
    end
  endtask

  task automatic test_gap();
    bit to;
    reset_dut(1);
    pulse_start(1);
    wait_idle(1, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL gap_timeout busy still %b exp 0", busy[1]); end
    // 4 idle GAP clocks plus the LOAD cycle separate TX_Done and the enable.
    for (int i = 1; i < 5; i++) begin
      n_tests++;
      if (en_cyc[1][i] - txd_cyc[1][i-1] != 5) begin
        n_fail++; $display("FAIL gap_len byte %0d got %0d exp 5", i, en_cyc[1][i] - txd_cyc[1][i-1]);
      end
    end
    n_tests++;
    if ({bytes[1][0], bytes[1][1], bytes[1][2], bytes[1][3], bytes[1][4]} !== 40'hE1C2850B17) begin
      n_fail++; $display("FAIL gap_bytes got %h exp e1c2850b17",
                         {bytes[1][0], bytes[1][1], bytes[1][2], bytes[1][3], bytes[1][4]});
    end
    n_tests++;
    if (bcnt[1] !== 16'd5 || done_cnt[1] != 1) begin
      n_fail++; $display("FAIL gap_end got count %0d done %0d exp 5 1", bcnt[1], done_cnt[1]);
    end
  endtask

  task automatic test_abort();
    // Abort during LOAD: no capture, no LFSR step.
    reset_dut(0);
    pulse_start(0);
    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    n_tests++;
    if (busy[0] !== 1'b0 || en_cnt[0] != 0 || txb[0] !== 8'h00) begin
      n_fail++; $display("FAIL abort_load got busy %b en %0d byte %h exp 0 0 00", busy[0], en_cnt[0], txb[0]);
    end
    // Abort during SEND while the UART is busy.
    ext_active[0] = 1'b1;
    pulse_start(0);
    tick(3);
    abort[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    ext_active[0] = 1'b0;
    tick(6);
    n_tests++;
    if (busy[0] !== 1'b0 || dv_cnt[0] != 0 || done_cnt[0] != 0 || en_cnt[0] != 1) begin
      n_fail++; $display("FAIL abort_send got busy %b dv %0d done %0d en %0d exp 0 0 0 1",
                         busy[0], dv_cnt[0], done_cnt[0], en_cnt[0]);
    end
    // Abort during WAIT_DONE of byte 2 on the 5-byte instance.
    reset_dut(1);
    pulse_start(1);
    for (int i = 0; i < 100 && dv_cnt[1] < 2; i++) tick(1);
    n_tests++;
    if (dv_cnt[1] != 2) begin n_fail++; $display("FAIL abort_wait_reach got dv %0d exp 2", dv_cnt[1]); end
    abort[1] = 1'b1;
    tick(8);
    abort[1] = 1'b0;
    n_tests++;
    if (bcnt[1] !== 16'd2) begin n_fail++; $display("FAIL abort_wait_count got %0d exp 2", bcnt[1]); end
    n_tests++;
    if (busy[1] !== 1'b0 || done_cnt[1] != 0 || en_cnt[1] != 2) begin
      n_fail++; $display("FAIL abort_wait_idle got busy %b done %0d en %0d exp 0 0 2",
                         busy[1], done_cnt[1], en_cnt[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    reset_dut(0);
    ext_active[0] = 1'b1;
    pulse_start(0);
    tick(2);
    n_tests++;
    if ({busy[0], txb[0]} !== {1'b1, 8'hE1}) begin
      n_fail++; $display("FAIL midrst_pre got busy %b byte %h exp 1 e1", busy[0], txb[0]);
    end
    rst_n[0] = 1'b0;
    #1;
    n_tests++;
    if ({en[0], dv[0], busy[0], done_o[0], txb[0], bcnt[0]} !== 28'h0) begin
      n_fail++; $display("FAIL midrst_async got %h exp 0", {en[0], dv[0], busy[0], done_o[0], txb[0], bcnt[0]});
    end
    tick(1);
    rst_n[0] = 1'b1;
    ext_active[0] = 1'b0;
    tick(10);
    n_tests++;
    if (done_cnt[0] != 0 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL midrst_quiet got done %0d busy %b exp 0 0", done_cnt[0], busy[0]);
    end
    pulse_start(0);
    wait_idle(0, to);
    n_tests++;
    if (to || bcnt[0] !== 16'd3 || done_cnt[0] != 1 ||
        {bytes[0][0], bytes[0][1], bytes[0][2]} !== 24'hE1C285) begin
      n_fail++; $display("FAIL midrst_restart got to %0b count %0d done %0d bytes %h exp 0 3 1 e1c285",
                         to, bcnt[0], done_cnt[0], {bytes[0][0], bytes[0][1], bytes[0][2]});
    end
  endtask

  task automatic test_ignore();
    bit to;
    reset_dut(0);
    ext_active[0] = 1'b1;
    pulse_start(0);
    tick(2);
    ext_done[0] = 1'b1;
    tick(1);
    ext_done[0] = 1'b0;
    n_tests++;
    if (bcnt[0] !== 16'd0) begin n_fail++; $display("FAIL ignore_done_send got %0d exp 0", bcnt[0]); end
    ext_active[0] = 1'b0;
    for (int i = 0; i < 50 && dv_cnt[0] == 0; i++) tick(1);
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    wait_idle(0, to);
    n_tests++;
    if (to || {bytes[0][0], bytes[0][1], bytes[0][2]} !== 24'hE1C285 || dv_cnt[0] != 3) begin
      n_fail++; $display("FAIL ignore_seq got to %0b bytes %h dv %0d exp 0 e1c285 3",
                         to, {bytes[0][0], bytes[0][1], bytes[0][2]}, dv_cnt[0]);
    end
    n_tests++;
    if (bcnt[0] !== 16'd3 || done_cnt[0] != 1) begin
      n_fail++; $display("FAIL ignore_count got %0d done %0d exp 3 1", bcnt[0], done_cnt[0]);
    end
    ext_done[0] = 1'b1;
    tick(1);
    ext_done[0] = 1'b0;
    tick(2);
    n_tests++;
    if (bcnt[0] !== 16'd3 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL ignore_done_idle got count %0d busy %b exp 3 0", bcnt[0], busy[0]);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; start[d] = 1'b0; abort[d] = 1'b0;
      ext_active[d] = 1'b0; ext_done[d] = 1'b0; lfsr[d] = 16'hACE1;
      m_active[d] = 1'b0; m_done[d] = 1'b0; m_cnt[d] = 0;
    end
    test_reset();
    test_burst();
    test_tx_busy();
    test_gap();
    test_abort();
    test_reset_mid();
    test_ignore();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
